// File: rtl/pwm_mixer_pkg.sv
// Shared constants, state encoding and attenuation helper for the PWM audio mixer.
package pwm_mixer_pkg;

  localparam logic [9:0] PHASE_MAX = 10'd1023;
  localparam logic [9:0] MIX_PHASE = 10'd1022;
  localparam logic [3:0] GAIN_FULL = 4'd8;

  typedef enum logic [1:0] {
    ST_MUTED     = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_UNMUTED   = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } ramp_state_e;

  localparam logic [1:0] ATTEN_FULL    = 2'd0;
  localparam logic [1:0] ATTEN_HALF    = 2'd1;
  localparam logic [1:0] ATTEN_QUARTER = 2'd2;
  localparam logic [1:0] ATTEN_OFF     = 2'd3;

  // Widened to the mix width so four channels can be summed without casts.
  function automatic logic [8:0] atten_scale(input logic [6:0] sample, input logic [1:0] code);
    logic [8:0] s;
    s = {2'b00, sample};
    case (code)
      ATTEN_FULL:    return s;
      ATTEN_HALF:    return s >> 1;
      ATTEN_QUARTER: return s >> 2;
      default:       return '0;
    endcase
  endfunction

endpackage

// File: rtl/pwm_mixer_mute_ramp.sv
// Soft-mute gain FSM: steps gain 0..8 one unit per frame so mute/unmute never pops.
module mute_ramp
  import pwm_mixer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       mute,
  output logic [3:0] gain,
  output logic       muted
);

  ramp_state_e state_q, state_d;
  logic [3:0]  gain_q, gain_d;

  always_comb begin
    // NOTE: hold values are assigned first so no path leaves a signal unassigned (no latch).
    state_d = state_q;
    gain_d  = gain_q;
    if (frame_tick) begin
      case (state_q)
        ST_MUTED: begin
          if (!mute) begin
            state_d = ST_RAMP_UP;
            gain_d  = 4'd1;
          end else begin
            gain_d  = 4'd0;
          end
        end
        ST_RAMP_UP: begin
          if (mute) begin
            state_d = ST_RAMP_DOWN;
            gain_d  = gain_q - 4'd1;
          end else if (gain_q >= 4'd7) begin
            state_d = ST_UNMUTED;
            gain_d  = GAIN_FULL;
          end else begin
            gain_d  = gain_q + 4'd1;
          end
        end
        ST_UNMUTED: begin
          if (mute) begin
            state_d = ST_RAMP_DOWN;
            gain_d  = 4'd7;
          end else begin
            gain_d  = GAIN_FULL;
          end
        end
        ST_RAMP_DOWN: begin
          if (!mute) begin
            state_d = ST_RAMP_UP;
            gain_d  = gain_q + 4'd1;
          end else if (gain_q <= 4'd1) begin
            // <= also covers a reversal that left gain at 0, keeping it from wrapping.
            state_d = ST_MUTED;
            gain_d  = 4'd0;
          end else begin
            gain_d  = gain_q - 4'd1;
          end
        end
        default: begin
          state_d = ST_MUTED;
          gain_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MUTED;
      gain_q  <= 4'd0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of its peers.
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  assign gain  = gain_q;
  assign muted = (state_q == ST_MUTED);

endmodule

// File: rtl/pwm_mixer.sv
// Four-voice attenuating mixer driving a 1024-cycle-frame PWM output with soft-mute ramping.
module pwm_mixer
  import pwm_mixer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] ch0_sample,
  input  logic [6:0] ch1_sample,
  input  logic [6:0] ch2_sample,
  input  logic [6:0] ch3_sample,
  input  logic [7:0] ch_atten,
  input  logic       mute,
  output logic [9:0] subsample_phase,
  output logic       sample_strobe,
  output logic       pwm_out,
  output logic       muted
);

  logic [9:0]  phase_q, phase_d;
  logic [8:0]  mix_q, mix_d;
  logic [8:0]  duty_q, duty_d, duty_new;
  logic        pwm_q, pwm_d;
  logic [12:0] scaled;
  logic [3:0]  gain;
  logic        frame_tick;

  assign frame_tick = (phase_q == PHASE_MAX);
  assign phase_d    = phase_q + 10'd1;

  assign mix_d = atten_scale(ch0_sample, ch_atten[1:0])
               + atten_scale(ch1_sample, ch_atten[3:2])
               + atten_scale(ch2_sample, ch_atten[5:4])
               + atten_scale(ch3_sample, ch_atten[7:6]);

  // gain is the value before this edge's FSM update, since both register on the same edge.
  assign scaled   = 13'(mix_q) * 13'(gain);
  assign duty_new = 9'(scaled >> 3);

  // The comparison uses the duty that will be live in the next cycle, so phase 0 sees the new frame's duty.
  always_comb begin
    duty_d = duty_q;
    if (frame_tick) duty_d = duty_new;
    pwm_d = ({1'b0, phase_d} < {1'b0, duty_d, 1'b0});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      mix_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (phase_q == MIX_PHASE) mix_q <= mix_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
    end
  end

  mute_ramp u_ramp (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .mute       (mute),
    .gain       (gain),
    .muted      (muted)
  );

  assign subsample_phase = phase_q;
  assign sample_strobe   = frame_tick;
  assign pwm_out         = pwm_q;

endmodule

// File: tb/tb_pwm_mixer.sv
// Directed self-checking bench for pwm_mixer: ramp, mixing, mute handling and mid-frame reset.
module tb_pwm_mixer;
  import pwm_mixer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] ch0_sample, ch1_sample, ch2_sample, ch3_sample;
  logic [7:0] ch_atten;
  logic       mute;
  logic [9:0] subsample_phase;
  logic       sample_strobe;
  logic       pwm_out;
  logic       muted;

  int n_checks = 0;
  int n_pass   = 0;

  pwm_mixer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ch0_sample      (ch0_sample),
    .ch1_sample      (ch1_sample),
    .ch2_sample      (ch2_sample),
    .ch3_sample      (ch3_sample),
    .ch_atten        (ch_atten),
    .mute            (mute),
    .subsample_phase (subsample_phase),
    .sample_strobe   (sample_strobe),
    .pwm_out         (pwm_out),
    .muted           (muted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advances at least one cycle, stopping on the falling edge where the phase equals p.
  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(subsample_phase) != p && n < 2100);
    if (int'(subsample_phase) != p) check("wait_phase_timeout", int'(subsample_phase), p);
  endtask

  // Called at the falling edge of phase 0; samples one full frame of pwm_out.
  task automatic measure(input string tag, input int exp_high);
    int hi, first_low, seq_err;
    hi = 0; first_low = -1; seq_err = 0;
    for (int i = 0; i < 1024; i++) begin
      if (pwm_out) hi++;
      else if (first_low < 0) first_low = i;
      if (int'(subsample_phase) != i) seq_err++;
      if (sample_strobe != (subsample_phase == 10'd1023)) seq_err++;
      @(negedge clk);
    end
    if (first_low < 0) first_low = 1024;
    check({tag, "_high_cycles"}, hi, exp_high);
    check({tag, "_first_low"}, first_low, exp_high);
    check({tag, "_phase_strobe_errs"}, seq_err, 0);
  endtask

  task automatic set_voices(input int c0, input int c1, input int c2, input int c3, input logic [7:0] at);
    ch0_sample = 7'(c0);
    ch1_sample = 7'(c1);
    ch2_sample = 7'(c2);
    ch3_sample = 7'(c3);
    ch_atten   = at;
  endtask

  initial begin
    rst_n = 1'b0;
    mute  = 1'b0;
    set_voices(127, 127, 127, 127, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_phase", int'(subsample_phase), 0);
    check("rst_strobe", int'(sample_strobe), 0);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_muted", int'(muted), 1);

    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_phase", int'(subsample_phase), 1);
    check("muted_before_frame1", int'(muted), 1);

    // Startup ramp: gain 1..8 over the first eight frame ends.
    for (int k = 1; k <= 8; k++) begin
      wait_phase(0);
      check($sformatf("ramp_gain_%0d", k), int'(dut.gain), k);
      check($sformatf("ramp_muted_%0d", k), int'(muted), 0);
    end
    check("ramp_state_unmuted", int'(dut.u_ramp.state_q), int'(ST_UNMUTED));
    wait_phase(0);
    measure("full_scale_f10", 1016);
    measure("full_scale_f11", 1016);

    // ch0 halved, others off: mix 50, duty 50.
    wait_phase(300);
    set_voices(100, 55, 55, 55, 8'b11111101);
    wait_phase(0);
    measure("mix50", 100);
    // Glitches away from phase 1022 must not disturb the mix.
    wait_phase(100);
    set_voices(0, 127, 127, 127, 8'h00);
    wait_phase(900);
    set_voices(100, 55, 55, 55, 8'b11111101);
    wait_phase(0);
    measure("mix50_glitch", 100);
    // ch0 off, ch1 quarter (13), ch2 half (27), ch3 full (120): mix 160.
    wait_phase(200);
    set_voices(100, 55, 55, 120, 8'h1B);
    wait_phase(0);
    measure("mix160", 320);

    // A mute pulse that misses phase 1023 changes nothing.
    wait_phase(10);
    mute = 1'b1;
    wait_phase(20);
    mute = 1'b0;
    wait_phase(0);
    check("pulse_gain", int'(dut.gain), 8);
    check("pulse_state", int'(dut.u_ramp.state_q), int'(ST_UNMUTED));
    measure("pulse_duty", 320);

    // Ramp down from UNMUTED.
    set_voices(127, 127, 127, 127, 8'h00);
    wait_phase(500);
    mute = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_phase(0);
      check($sformatf("down_gain_%0d", k), int'(dut.gain), 8 - k);
      check($sformatf("down_muted_%0d", k), int'(muted), (k == 8) ? 1 : 0);
    end
    measure("down_last_step", 126);
    measure("muted_silent_a", 0);
    measure("muted_silent_b", 0);

    // Ramp back up, then exercise both reversal directions.
    mute = 1'b0;
    for (int k = 1; k <= 8; k++) wait_phase(0);
    check("reup_gain", int'(dut.gain), 8);
    wait_phase(100);
    mute = 1'b1;
    for (int k = 1; k <= 4; k++) wait_phase(0);
    check("rd_gain4", int'(dut.gain), 4);
    check("rd_state", int'(dut.u_ramp.state_q), int'(ST_RAMP_DOWN));
    wait_phase(200);
    mute = 1'b0;
    wait_phase(0);
    check("rev_up_gain", int'(dut.gain), 5);
    check("rev_up_state", int'(dut.u_ramp.state_q), int'(ST_RAMP_UP));
    wait_phase(0);
    check("rev_up_gain6", int'(dut.gain), 6);
    wait_phase(300);
    mute = 1'b1;
    wait_phase(0);
    check("rev_down_gain", int'(dut.gain), 5);
    check("rev_down_state", int'(dut.u_ramp.state_q), int'(ST_RAMP_DOWN));
    mute = 1'b0;
    wait_phase(0);
    check("rev_up2_gain", int'(dut.gain), 6);

    // Mid-frame reset: duty is 508*5>>3 = 317, so pwm is high at phase 600.
    wait_phase(600);
    check("pre_reset_pwm", int'(pwm_out), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_phase", int'(subsample_phase), 0);
    check("mid_rst_strobe", int'(sample_strobe), 0);
    check("mid_rst_pwm", int'(pwm_out), 0);
    check("mid_rst_muted", int'(muted), 1);
    check("mid_rst_gain", int'(dut.gain), 0);
    repeat (2) @(negedge clk);
    check("mid_rst_hold_phase", int'(subsample_phase), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_phase", int'(subsample_phase), 1);
    check("post_rst_muted", int'(muted), 1);
    wait_phase(0);
    check("post_rst_gain", int'(dut.gain), 1);
    check("post_rst_state", int'(dut.u_ramp.state_q), int'(ST_RAMP_UP));
    measure("post_rst_f2", 0);
    measure("post_rst_f3", 126);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_mixer.md
PWM_MIXER -- requirements
Module: pwm_mixer

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port ch0_sample..ch3_sample, input, 7 bits each: unsigned voice samples (triangle, square, saw, noise generators).
REQ-004 SHALL have port ch_atten, input, 8 bits: 2 bits per channel, [2k+1:2k] for channel k; 0=full, 1=half (>>1), 2=quarter (>>2), 3=off.
REQ-005 SHALL have port mute, input, 1 bit: level request for soft mute.
REQ-006 SHALL have port subsample_phase, output, 10 bits: free-running frame phase, broadcast to the voice generators.
REQ-007 SHALL have port sample_strobe, output, 1 bit: high exactly while subsample_phase==1023.
REQ-008 SHALL have port pwm_out, output, 1 bit: registered PWM audio output.
REQ-009 SHALL have port muted, output, 1 bit: high iff the FSM is in MUTED.

Function
REQ-010 subsample_phase SHALL increment by 1 every clk cycle and wrap 1023->0; frame = 1024 cycles.
REQ-011 At phase 1022, mix_reg (9 bits) SHALL load the sum over k of (chk_sample >> shift_k), with off channels contributing 0; max 508, no overflow.
REQ-012 At phase 1023, duty_reg (9 bits) SHALL load (mix_reg * gain) >> 3, 13-bit intermediate, truncated; uses gain value before that edge's update.
REQ-013 pwm_out SHALL be registered: high for next-cycle phase p iff p < 2*duty_reg; duty 0 -> constantly low, duty 508 -> high 1016 of 1024 cycles.
REQ-014 New duty_reg SHALL take effect from phase 0 of the following frame; no mid-frame duty change.
REQ-015 gain SHALL be 4 bits, range 0..8; FSM states MUTED, RAMP_UP, UNMUTED, RAMP_DOWN; evaluated only at phase 1023.
REQ-016 MUTED: mute=0 -> RAMP_UP, gain<=1; else stay, gain 0.
REQ-017 RAMP_UP: mute=1 -> RAMP_DOWN, gain<=gain-1; else gain==7 -> UNMUTED, gain<=8; else gain<=gain+1.
REQ-018 UNMUTED: mute=1 -> RAMP_DOWN, gain<=7; else stay, gain 8.
REQ-019 RAMP_DOWN: mute=0 -> RAMP_UP, gain<=gain+1; else gain==1 -> MUTED, gain<=0; else gain<=gain-1.
REQ-020 mute changes mid-frame SHALL be sampled only at phase 1023; pulses shorter than a frame not covering phase 1023 SHALL be ignored.
REQ-021 Sample inputs and ch_atten SHALL be sampled only at phase 1022; values at other phases SHALL have no effect.

Reset
REQ-022 While rst_n=0: subsample_phase=0, sample_strobe=0, mix_reg=0, duty_reg=0, pwm_out=0, gain=0, state=MUTED, muted=1.
REQ-023 Assertion mid-frame SHALL clear immediately; after release, phase SHALL count from 0 on the first edge and startup SHALL ramp from MUTED (pop-free).

Structure
REQ-024 Shared package SHALL hold PHASE_MAX=1023, MIX_PHASE=1022, GAIN_FULL=8, the 2-bit FSM state typedef and atten code constants.
REQ-025 The gain FSM SHALL be one sub-module, mute_ramp (inputs clk, rst_n, frame_tick, mute; outputs gain[3:0], muted).

Verification
REQ-026 Reset release, mute=0, all channels 127, ch_atten=0 -> gain 1..8 over the first 8 frame ends, muted low after frame 1; from frame 10 duty_reg=508, pwm_out high for exactly 1016 cycles per frame.
REQ-027 Steady UNMUTED, ch0=100, ch_atten=8'b11111101, others 55 -> mix 50, duty 50, pwm_out high for cycles 0..99 of each frame.
REQ-028 UNMUTED, mute asserted at phase 500 -> gain 7 at next phase 1023, reaches 0 and muted=1 after 8 boundaries; pwm_out constantly low thereafter.
REQ-029 mute toggled 1 in RAMP_DOWN at gain 4, deasserted before next boundary -> RAMP_UP, gain 5; mute pulse phases 10..20 in UNMUTED -> no change.
REQ-030 Check sample_strobe high only at phase 1023, wrap 1023->0; rst_n low at phase 600 -> all outputs to reset values same cycle, phase 0 after release.
